sm83_regfile: RTL and testbench

SM83_REGFILE -- requirements
Module: sm83_regfile

---
 rtl/sm83_pkg.sv | 20 ++
 rtl/sm83_idu.sv | 9 +
 rtl/sm83_regfile.sv | 84 ++++++++
 tb/tb_sm83_regfile.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sm83_pkg.sv
// sm83_pkg: shared types and helpers for the SM83 register file.
// Holds the byte and pair select encodings, the flag layout, the debug register vector
// and the pair-to-byte index helper.
package sm83_pkg;
   typedef logic [7:0] r8_t;
   typedef enum logic [3:0] {R_A, R_F, R_B, R_C, R_D, R_E, R_H, R_L, R_IR, R_IE, R_SPH, R_SPL, R_PCH, R_PCL} r8_sel_e;
   typedef enum logic [2:0] {P_AF, P_BC, P_DE, P_HL, P_SP, P_PC} r16_sel_e;
   typedef struct packed { logic z; logic n; logic h; logic c; } flags_t;
   typedef struct packed {
      r8_t a;
      flags_t f;
      r8_t b, c, d, e, h, l, ir, ie;
      logic [15:0] sp, pc;
   } reg_vec_t;
   // Byte index of a pair's high half; the low half is the next index.
   // SP and PC sit after IR/IE, which is why they skip two slots.
   function automatic logic [3:0] pair_hi(input logic [2:0] p);
      return p < 3'd4 ? {p, 1'b0} : {p, 1'b0} + 4'd2;
   endfunction
endpackage

// File: rtl/sm83_idu.sv
// sm83_idu: 16-bit incrementer/decrementer, modulo 2^16.
// Ports: a (operand), dec (1 = decrement, 0 = increment), y (result).
module sm83_idu (
   input  logic [15:0] a,
   input  logic        dec,
   output logic [15:0] y
);
   assign y = dec ? a - 16'd1 : a + 16'd1;
endmodule

// File: rtl/sm83_regfile.sv
// sm83_regfile: SM83 register file with 8-bit and 16-bit access.
// Ports: clk, rst (async, active high); NUM_RD combinational byte read ports (rd_sel/rd_data);
// one pair read port (rd16_sel/rd16_data); byte write (wr8_*), pair write (wr16_*);
// per-flag write (flg_wen/flg_in, {z,n,h,c}); pair inc/dec (idu_*); PC increment (pc_inc);
// full registered state (regs).
module sm83_regfile
   import sm83_pkg::*;
#(
   parameter int          NUM_RD = 2,
   parameter int          BYPASS = 1,
   parameter logic [15:0] PC_RST = 16'h0000,
   parameter logic [15:0] SP_RST = 16'hFFFE
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_RD-1:0][3:0] rd_sel,
   output logic [NUM_RD-1:0][7:0] rd_data,
   input  logic [2:0]             rd16_sel,
   output logic [15:0]            rd16_data,
   input  logic                   wr8_en,
   input  logic [3:0]             wr8_sel,
   input  logic [7:0]             wr8_data,
   input  logic                   wr16_en,
   input  logic [2:0]             wr16_sel,
   input  logic [15:0]            wr16_data,
   input  logic [3:0]             flg_wen,
   input  logic [3:0]             flg_in,
   input  logic                   idu_en,
   input  logic                   idu_dec,
   input  logic [2:0]             idu_sel,
   input  logic                   pc_inc,
   output reg_vec_t               regs
);
   // Slots 14 and 15 stand for the unused byte encodings; they stay zero so unused
   // selects read 0 and writes to them vanish.
   r8_t cur [16];
   r8_t nxt [16];
   r8_t src [16];
   logic [15:0] idu_a, idu_y, pc_nx;
   logic [3:0] idu_hi, wr16_hi;
   logic idu_ok, wr16_ok;
   assign idu_hi  = pair_hi(idu_sel);
   assign wr16_hi = pair_hi(wr16_sel);
   assign idu_ok  = idu_en && idu_sel != P_AF && idu_sel < 3'd6;
   assign wr16_ok = wr16_en && wr16_sel < 3'd6;
   assign idu_a   = {cur[idu_hi], cur[idu_hi + 4'd1]};
   assign pc_nx   = {cur[R_PCH], cur[R_PCL]} + 16'd1;
   sm83_idu u_idu (.a(idu_a), .dec(idu_dec), .y(idu_y));
   // Sources are applied lowest priority first so later assignments win per byte.
   always_comb begin
      for (int i = 0; i < 16; i++) begin
         nxt[i] = cur[i];
         if (pc_inc && 4'(i) == R_PCH) nxt[i] = pc_nx[15:8];
         if (pc_inc && 4'(i) == R_PCL) nxt[i] = pc_nx[7:0];
         if (wr8_en && wr8_sel == 4'(i)) nxt[i] = wr8_data;
         if (idu_ok && idu_hi == 4'(i)) nxt[i] = idu_y[15:8];
         if (idu_ok && idu_hi + 4'd1 == 4'(i)) nxt[i] = idu_y[7:0];
         if (wr16_ok && wr16_hi == 4'(i)) nxt[i] = wr16_data[15:8];
         if (wr16_ok && wr16_hi + 4'd1 == 4'(i)) nxt[i] = wr16_data[7:0];
      end
      nxt[R_F] = {(flg_wen & flg_in) | (~flg_wen & nxt[R_F][7:4]), 4'h0};
      nxt[14] = 8'h00;
      nxt[15] = 8'h00;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) cur[i] <= 8'h00;
         cur[R_SPH] <= SP_RST[15:8];
         cur[R_SPL] <= SP_RST[7:0];
         cur[R_PCH] <= PC_RST[15:8];
         cur[R_PCL] <= PC_RST[7:0];
      end else begin
         for (int i = 0; i < 16; i++) cur[i] <= nxt[i];
      end
   end
   always_comb begin
      for (int i = 0; i < 16; i++) src[i] = BYPASS != 0 ? nxt[i] : cur[i];
      for (int k = 0; k < NUM_RD; k++) rd_data[k] = src[rd_sel[k]];
      rd16_data = rd16_sel < 3'd6 ? {src[pair_hi(rd16_sel)], src[pair_hi(rd16_sel) + 4'd1]} : 16'h0000;
   end
   assign regs = reg_vec_t'({cur[R_A], cur[R_F][7:4], cur[R_B], cur[R_C], cur[R_D], cur[R_E],
                             cur[R_H], cur[R_L], cur[R_IR], cur[R_IE],
                             cur[R_SPH], cur[R_SPL], cur[R_PCH], cur[R_PCL]});
endmodule

// File: tb/tb_sm83_regfile.sv
// tb_sm83_regfile: self-checking bench for sm83_regfile against a pair-level reference model.
module tb_sm83_regfile;
   import sm83_pkg::*;
   logic clk = 0, rst = 1;
   logic [1:0][3:0] rd_sel;
   logic [1:0][7:0] rd_data, rd_data0;
   logic [2:0] rd16_sel;
   logic [15:0] rd16_data, rd16_data0;
   logic wr8_en, wr16_en, idu_en, idu_dec, pc_inc;
   logic [3:0] wr8_sel, flg_wen, flg_in;
   logic [7:0] wr8_data;
   logic [2:0] wr16_sel, idu_sel;
   logic [15:0] wr16_data;
   reg_vec_t regs, regs0;
   int checks = 0, errors = 0;
   logic [7:0] m [16];
   logic [7:0] nm [16];
   int hi_tab [6] = '{0, 2, 4, 6, 10, 12};

   always #5 clk = ~clk;

   sm83_regfile dut (.clk(clk), .rst(rst), .rd_sel(rd_sel), .rd_data(rd_data), .rd16_sel(rd16_sel),
      .rd16_data(rd16_data), .wr8_en(wr8_en), .wr8_sel(wr8_sel), .wr8_data(wr8_data),
      .wr16_en(wr16_en), .wr16_sel(wr16_sel), .wr16_data(wr16_data), .flg_wen(flg_wen),
      .flg_in(flg_in), .idu_en(idu_en), .idu_dec(idu_dec), .idu_sel(idu_sel), .pc_inc(pc_inc),
      .regs(regs));
   sm83_regfile #(.BYPASS(0)) dut0 (.clk(clk), .rst(rst), .rd_sel(rd_sel), .rd_data(rd_data0),
      .rd16_sel(rd16_sel), .rd16_data(rd16_data0), .wr8_en(wr8_en), .wr8_sel(wr8_sel),
      .wr8_data(wr8_data), .wr16_en(wr16_en), .wr16_sel(wr16_sel), .wr16_data(wr16_data),
      .flg_wen(flg_wen), .flg_in(flg_in), .idu_en(idu_en), .idu_dec(idu_dec), .idu_sel(idu_sel),
      .pc_inc(pc_inc), .regs(regs0));

   function automatic logic [15:0] get16(input int p);
      return p < 6 ? {m[hi_tab[p]], m[hi_tab[p] + 1]} : 16'h0000;
   endfunction
   function automatic logic [15:0] getn16(input int p);
      return p < 6 ? {nm[hi_tab[p]], nm[hi_tab[p] + 1]} : 16'h0000;
   endfunction
   function automatic void put16(input int p, input logic [15:0] v);
      nm[hi_tab[p]] = v[15:8];
      nm[hi_tab[p] + 1] = v[7:0];
   endfunction
   function automatic reg_vec_t exp_regs();
      return reg_vec_t'({m[0], m[1][7:4], m[2], m[3], m[4], m[5], m[6], m[7], m[8], m[9],
                         m[10], m[11], m[12], m[13]});
   endfunction
   // Apply every requested operation from the lowest priority to the highest.
   function automatic void model_next();
      nm = m;
      if (pc_inc) put16(5, get16(5) + 16'd1);
      if (wr8_en && wr8_sel < 4'd14) nm[wr8_sel] = wr8_data;
      if (idu_en && idu_sel >= 3'd1 && idu_sel <= 3'd5)
         put16(int'(idu_sel), idu_dec ? get16(int'(idu_sel)) - 16'd1 : get16(int'(idu_sel)) + 16'd1);
      if (wr16_en && wr16_sel < 3'd6) put16(int'(wr16_sel), wr16_data);
      nm[1][3:0] = 4'h0;
      for (int b = 0; b < 4; b++) if (flg_wen[b]) nm[1][4 + b] = flg_in[b];
   endfunction
   function automatic void model_reset();
      for (int i = 0; i < 16; i++) m[i] = 8'h00;
      m[10] = 8'hFF;
      m[11] = 8'hFE;
   endfunction
   task automatic idle();
      rd_sel = '0; rd16_sel = 0; wr8_en = 0; wr8_sel = 0; wr8_data = 0;
      wr16_en = 0; wr16_sel = 0; wr16_data = 0; flg_wen = 0; flg_in = 0;
      idu_en = 0; idu_dec = 0; idu_sel = 0; pc_inc = 0;
   endtask
   task automatic tick();
      #1;
      model_next();
      @(posedge clk);
      m = nm;
      #1;
   endtask

   task automatic test_reset();
      idle();
      rst = 1;
      model_reset();
      #12 rst = 0;
      #1;
      checks++; if (regs.pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h want 0000", regs.pc); end
      checks++; if (regs.sp !== 16'hFFFE) begin errors++; $display("FAIL reset_sp got %h want FFFE", regs.sp); end
      checks++; if ({regs.a, regs.b, regs.c, regs.d, regs.e, regs.h, regs.l} !== 56'h0)
         begin errors++; $display("FAIL reset_r8 got %h want 0", {regs.a, regs.b, regs.c, regs.d, regs.e, regs.h, regs.l}); end
      rd16_sel = 3'(P_AF);
      #1;
      checks++; if (rd16_data !== 16'h0000) begin errors++; $display("FAIL reset_af got %h want 0000", rd16_data); end
      checks++; if (regs0 !== regs) begin errors++; $display("FAIL reset_nobyp got %h want %h", regs0, regs); end
   endtask

   task automatic test_hl();
      idle();
      wr16_en = 1; wr16_sel = 3'(P_HL); wr16_data = 16'hABCD; rd_sel[0] = 4'(R_H);
      #1;
      checks++; if (rd_data[0] !== 8'hAB) begin errors++; $display("FAIL hl_bypass got %h want AB", rd_data[0]); end
      checks++; if (rd_data0[0] !== 8'h00) begin errors++; $display("FAIL hl_nobypass got %h want 00", rd_data0[0]); end
      tick();
      idle();
      rd_sel[0] = 4'(R_H); rd_sel[1] = 4'(R_L); rd16_sel = 3'(P_HL);
      #1;
      checks++; if (rd_data[0] !== 8'hAB) begin errors++; $display("FAIL hl_h got %h want AB", rd_data[0]); end
      checks++; if (rd_data[1] !== 8'hCD) begin errors++; $display("FAIL hl_l got %h want CD", rd_data[1]); end
      checks++; if (rd16_data !== 16'hABCD) begin errors++; $display("FAIL hl_pair got %h want ABCD", rd16_data); end
   endtask

   task automatic test_wrap();
      idle(); wr16_en = 1; wr16_sel = 3'(P_HL); wr16_data = 16'hFFFF; tick();
      idle(); idu_en = 1; idu_sel = 3'(P_HL); tick();
      idle();
      checks++; if ({regs.h, regs.l} !== 16'h0000) begin errors++; $display("FAIL wrap_hl got %h want 0000", {regs.h, regs.l}); end
      wr16_en = 1; wr16_sel = 3'(P_SP); wr16_data = 16'h0000; tick();
      idle(); idu_en = 1; idu_dec = 1; idu_sel = 3'(P_SP); tick();
      idle();
      checks++; if (regs.sp !== 16'hFFFF) begin errors++; $display("FAIL wrap_sp got %h want FFFF", regs.sp); end
      wr16_en = 1; wr16_sel = 3'(P_PC); wr16_data = 16'hFFFF; tick();
      idle(); pc_inc = 1; tick();
      idle();
      checks++; if (regs.pc !== 16'h0000) begin errors++; $display("FAIL wrap_pc got %h want 0000", regs.pc); end
      idu_en = 1; idu_sel = 3'(P_AF); wr16_en = 1; wr16_sel = 3'(P_AF); wr16_data = 16'h12FF; tick();
      idle(); idu_en = 1; idu_sel = 3'(P_AF); tick();
      idle();
      checks++; if ({regs.a, regs.f, 4'h0} !== 16'h12F0) begin errors++; $display("FAIL idu_af got %h want 12F0", {regs.a, regs.f, 4'h0}); end
   endtask

   task automatic test_collision();
      idle(); wr16_en = 1; wr16_sel = 3'(P_DE); wr16_data = 16'h00FF; tick();
      idle();
      wr16_en = 1; wr16_sel = 3'(P_BC); wr16_data = 16'h1234;
      wr8_en = 1; wr8_sel = 4'(R_C); wr8_data = 8'h55;
      idu_en = 1; idu_sel = 3'(P_DE);
      tick();
      idle();
      rd16_sel = 3'(P_BC); #1;
      checks++; if (rd16_data !== 16'h1234) begin errors++; $display("FAIL coll_bc got %h want 1234", rd16_data); end
      rd16_sel = 3'(P_DE); #1;
      checks++; if (rd16_data !== 16'h0100) begin errors++; $display("FAIL coll_de got %h want 0100", rd16_data); end
   endtask

   task automatic test_flags();
      idle(); wr8_en = 1; wr8_sel = 4'(R_F); wr8_data = 8'hFF; tick();
      idle(); rd_sel[0] = 4'(R_F); #1;
      checks++; if (rd_data[0] !== 8'hF0) begin errors++; $display("FAIL flag_f0 got %h want F0", rd_data[0]); end
      flg_wen = 4'b0101; flg_in = 4'b0000; tick();
      idle(); rd_sel[0] = 4'(R_F); #1;
      checks++; if (rd_data[0] !== 8'hA0) begin errors++; $display("FAIL flag_a0 got %h want A0", rd_data[0]); end
      wr8_en = 1; wr8_sel = 4'(R_F); wr8_data = 8'h00; flg_wen = 4'b1100; flg_in = 4'b1111; tick();
      idle(); rd_sel[0] = 4'(R_F); #1;
      checks++; if (rd_data[0] !== 8'hC0) begin errors++; $display("FAIL flag_prio got %h want C0", rd_data[0]); end
   endtask

   task automatic test_async_reset();
      idle(); wr16_en = 1; wr16_sel = 3'(P_PC); wr16_data = 16'h1234; tick();
      idle(); idu_en = 1; idu_sel = 3'(P_PC);
      #2 rst = 1;
      model_reset();
      #1;
      checks++; if (regs.pc !== 16'h0000) begin errors++; $display("FAIL arst_pc got %h want 0000", regs.pc); end
      @(posedge clk);
      #2 rst = 0;
      idle();
      @(posedge clk); #1;
      checks++; if (regs.pc !== 16'h0000) begin errors++; $display("FAIL arst_noinc got %h want 0000", regs.pc); end
      pc_inc = 1; tick();
      idle();
      checks++; if (regs.pc !== 16'h0001) begin errors++; $display("FAIL arst_after got %h want 0001", regs.pc); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         rd_sel[0] = 4'($urandom_range(0, 15)); rd_sel[1] = 4'($urandom_range(0, 15));
         rd16_sel = 3'($urandom_range(0, 7));
         wr8_en = ($urandom_range(0, 2) == 0); wr8_sel = 4'($urandom_range(0, 15)); wr8_data = 8'($urandom);
         wr16_en = ($urandom_range(0, 3) == 0); wr16_sel = 3'($urandom_range(0, 7)); wr16_data = 16'($urandom);
         flg_wen = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0; flg_in = 4'($urandom);
         idu_en = ($urandom_range(0, 2) == 0); idu_dec = 1'($urandom); idu_sel = 3'($urandom_range(0, 7));
         pc_inc = 1'($urandom);
         #1;
         model_next();
         for (int k = 0; k < 2; k++) begin
            checks++; if (rd_data[k] !== nm[rd_sel[k]])
               begin errors++; $display("FAIL rnd_rd%0d sel %0d got %h want %h", k, rd_sel[k], rd_data[k], nm[rd_sel[k]]); end
            checks++; if (rd_data0[k] !== m[rd_sel[k]])
               begin errors++; $display("FAIL rnd_rd0_%0d sel %0d got %h want %h", k, rd_sel[k], rd_data0[k], m[rd_sel[k]]); end
         end
         checks++; if (rd16_data !== getn16(int'(rd16_sel)))
            begin errors++; $display("FAIL rnd_rd16 sel %0d got %h want %h", rd16_sel, rd16_data, getn16(int'(rd16_sel))); end
         checks++; if (rd16_data0 !== get16(int'(rd16_sel)))
            begin errors++; $display("FAIL rnd_rd16_0 sel %0d got %h want %h", rd16_sel, rd16_data0, get16(int'(rd16_sel))); end
         @(posedge clk);
         m = nm;
         #1;
         checks++; if (regs !== exp_regs()) begin errors++; $display("FAIL rnd_regs got %h want %h", regs, exp_regs()); end
         checks++; if (regs0 !== exp_regs()) begin errors++; $display("FAIL rnd_regs0 got %h want %h", regs0, exp_regs()); end
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_hl();
      test_wrap();
      test_collision();
      test_flags();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
